cms_trace_packer: RTL and testbench

//  Parametrised successor to the fixed-width CMS capture path. Captures one trace item
//  (instr, pc, performance events) per retired instruction into an internal FIFO.

---
 rtl/cms_trace_packer.sv | 183 ++++++++++++++++++
 tb/tb_cms_trace_packer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cms_trace_packer.sv
// Trace capture packer: filters retired-instruction trace items into a FWFT FIFO and drains
// them as AXI-Stream beats, with packet tlast, idle-timeout terminators and a drop counter.
module cms_trace_packer #(
    parameter int unsigned XLEN              = 64,
    parameter int unsigned AXI_DATA_WIDTH    = 512,
    parameter int unsigned NO_OF_PERF_EVENTS = 37,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 1024,
    parameter int unsigned CTRL_ADDR_WIDTH   = 8,
    parameter int unsigned CTRL_DATA_WIDTH   = 64,
    parameter bit          CTRL_WE_POSEDGE   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  instr,
    input  logic [XLEN-1:0]              pc,
    input  logic                         pc_valid,
    input  logic [NO_OF_PERF_EVENTS-1:0] performance_events,
    input  logic                         en,
    input  logic [CTRL_ADDR_WIDTH-1:0]   ctrl_addr,
    input  logic [CTRL_DATA_WIDTH-1:0]   ctrl_wdata,
    input  logic                         ctrl_write_enable,
    input  logic [31:0]                  tlast_interval,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic [AXI_DATA_WIDTH-1:0]    M_AXIS_tdata,
    output logic                         M_AXIS_tlast,
    output logic [31:0]                  drop_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_CFG   = CTRL_ADDR_WIDTH'(0);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_LO    = CTRL_ADDR_WIDTH'(1);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_HI    = CTRL_ADDR_WIDTH'(2);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_CLEAR = CTRL_ADDR_WIDTH'(3);
    localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);

    // Compact FIFO entry; the wide tdata is rebuilt from it at the head.
    typedef struct packed {
        logic                         item;
        logic                         last;
        logic [NO_OF_PERF_EVENTS-1:0] ev;
        logic [XLEN-1:0]              pc;
        logic [31:0]                  instr;
    } entry_t;

    entry_t           mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full, empty, push, pop;
    entry_t           wr_data, head;

    logic             we_q, ctrl_wr;
    logic             trace_en_q, filt_en_q;
    logic [XLEN-1:0]  filt_lo_q, filt_hi_q;
    logic [31:0]      beat_cnt_q, beat_cnt_d;
    logic [31:0]      idle_cnt_q, idle_cnt_d;
    logic [31:0]      drop_cnt_q, drop_cnt_d;
    logic [31:0]      interval_m1;
    logic             in_range, cap, item_wr, term_wr, drop, item_last, timeout_hit, clear_drop;

    if (CTRL_DATA_WIDTH > XLEN) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^ctrl_wdata[CTRL_DATA_WIDTH-1:XLEN];
    end

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = ~empty & M_AXIS_tready;

    assign ctrl_wr    = CTRL_WE_POSEDGE ? (ctrl_write_enable & ~we_q) : ctrl_write_enable;
    assign clear_drop = ctrl_wr & (ctrl_addr == ADDR_CLEAR);

    assign in_range    = (pc >= filt_lo_q) && (pc <= filt_hi_q);
    assign cap         = pc_valid & en & trace_en_q & (~filt_en_q | in_range);
    assign interval_m1 = (tlast_interval == 32'd0) ? 32'd0 : tlast_interval - 32'd1;
    assign item_last   = (beat_cnt_q == interval_m1);
    assign timeout_hit = (TIMEOUT != 32'd0) && (beat_cnt_q != 32'd0) && (idle_cnt_q == TIMEOUT);

    // Capture has priority over the terminator; full is judged before this cycle's pop.
    assign item_wr = cap & ~full;
    assign drop    = cap & full;
    assign term_wr = timeout_hit & ~cap & ~full;
    assign push    = item_wr | term_wr;

    always_comb begin
        wr_data = '0;
        if (item_wr) begin
            wr_data.item  = 1'b1;
            wr_data.last  = item_last;
            wr_data.ev    = performance_events;
            wr_data.pc    = pc;
            wr_data.instr = instr;
        end else begin
            wr_data.last = 1'b1;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (item_wr) begin
            beat_cnt_d = item_last ? 32'd0 : beat_cnt_q + 32'd1;
        end else if (term_wr) begin
            beat_cnt_d = 32'd0;
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (cap || term_wr) begin
            idle_cnt_d = 32'd0;
        end else if ((beat_cnt_q != 32'd0) && (idle_cnt_q < TIMEOUT)) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_drop) begin
            drop_cnt_d = 32'd0;
        end else if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            trace_en_q <= 1'b1;
            filt_en_q  <= 1'b0;
            filt_lo_q  <= '0;
            filt_hi_q  <= '1;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            we_q       <= ctrl_write_enable;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (ctrl_wr) begin
                unique case (ctrl_addr)
                    ADDR_CFG: begin
                        trace_en_q <= ctrl_wdata[0];
                        filt_en_q  <= ctrl_wdata[1];
                    end
                    ADDR_LO: filt_lo_q <= ctrl_wdata[XLEN-1:0];
                    ADDR_HI: filt_hi_q <= ctrl_wdata[XLEN-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign head = mem[rd_ptr_q];

    always_comb begin
        M_AXIS_tdata = '0;
        if (!empty && head.item) begin
            M_AXIS_tdata[31:0]                         = head.instr;
            M_AXIS_tdata[32 +: XLEN]                   = head.pc;
            M_AXIS_tdata[32+XLEN +: NO_OF_PERF_EVENTS] = head.ev;
            M_AXIS_tdata[AXI_DATA_WIDTH-1]             = 1'b1;
        end
    end

    assign M_AXIS_tvalid = ~empty;
    assign M_AXIS_tlast  = ~empty & head.last;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_cms_trace_packer.sv
// Directed bench for cms_trace_packer: stimulus pushes expected beats to a scoreboard queue,
// a negedge monitor pops and compares them on every accepted AXI-Stream beat.
module tb_cms_trace_packer;

    localparam int XLEN = 64;
    localparam int AXW  = 512;
    localparam int NE   = 37;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [NE-1:0]   performance_events;
    logic            en;
    logic [7:0]      ctrl_addr;
    logic [63:0]     ctrl_wdata;
    logic            ctrl_write_enable;
    logic [31:0]     tlast_interval;
    logic            M_AXIS_tvalid;
    logic            M_AXIS_tready;
    logic [AXW-1:0]  M_AXIS_tdata;
    logic            M_AXIS_tlast;
    logic [31:0]     drop_count;

    typedef struct packed {
        logic [AXW-1:0] d;
        logic           l;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   model_beat = 0;

    always #5 clk = ~clk;

    cms_trace_packer #(
        .XLEN              (XLEN),
        .AXI_DATA_WIDTH    (AXW),
        .NO_OF_PERF_EVENTS (NE),
        .FIFO_DEPTH        (16),
        .TIMEOUT_CYCLES    (8),
        .CTRL_ADDR_WIDTH   (8),
        .CTRL_DATA_WIDTH   (64),
        .CTRL_WE_POSEDGE   (1'b1)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instr              (instr),
        .pc                 (pc),
        .pc_valid           (pc_valid),
        .performance_events (performance_events),
        .en                 (en),
        .ctrl_addr          (ctrl_addr),
        .ctrl_wdata         (ctrl_wdata),
        .ctrl_write_enable  (ctrl_write_enable),
        .tlast_interval     (tlast_interval),
        .M_AXIS_tvalid      (M_AXIS_tvalid),
        .M_AXIS_tready      (M_AXIS_tready),
        .M_AXIS_tdata       (M_AXIS_tdata),
        .M_AXIS_tlast       (M_AXIS_tlast),
        .drop_count         (drop_count)
    );

    task automatic chk(input string tag, input logic [AXW-1:0] obs, input logic [AXW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AXW-1:0] mk_item(input logic [31:0] i, input logic [XLEN-1:0] p,
                                               input logic [NE-1:0] e);
        logic [AXW-1:0] d;
        d = '0;
        d[31:0]        = i;
        d[32 +: XLEN]  = p;
        d[96 +: NE]    = e;
        d[AXW-1]       = 1'b1;
        return d;
    endfunction

    // One-cycle capture attempt; when kept, the expected beat and its tlast go to the scoreboard.
    task automatic cap(input logic [XLEN-1:0] p, input logic [31:0] i, input bit kept);
        logic [NE-1:0] e;
        int            lim;
        exp_t          x;
        e = NE'({$urandom, $urandom});
        pc_valid = 1'b1;
        pc = p;
        instr = i;
        performance_events = e;
        if (kept) begin
            lim = (tlast_interval == 0) ? 1 : int'(tlast_interval);
            x.d = mk_item(i, p, e);
            x.l = (model_beat == lim - 1);
            model_beat = x.l ? 0 : model_beat + 1;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
    endtask

    task automatic ctrl_write(input logic [7:0] a, input logic [63:0] d);
        ctrl_addr = a;
        ctrl_wdata = d;
        ctrl_write_enable = 1'b1;
        @(posedge clk);
        #1;
        ctrl_write_enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n && M_AXIS_tvalid && M_AXIS_tready) begin
            chk("beat_expected", AXW'(sb.size() != 0), AXW'(1));
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("tdata", M_AXIS_tdata, x.d);
                chk("tlast", AXW'(M_AXIS_tlast), AXW'(x.l));
            end
        end
    end

    initial begin
        int seen;
        rst_n = 1'b1;
        instr = '0;
        pc = '0;
        pc_valid = 1'b0;
        performance_events = '0;
        en = 1'b1;
        ctrl_addr = '0;
        ctrl_wdata = '0;
        ctrl_write_enable = 1'b0;
        tlast_interval = 32'd4;
        M_AXIS_tready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_tvalid", AXW'(M_AXIS_tvalid), '0);
        chk("rst_tlast", AXW'(M_AXIS_tlast), '0);
        chk("rst_tdata", M_AXIS_tdata, '0);
        chk("rst_drop", AXW'(drop_count), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Packets of 4 at full throughput
        M_AXIS_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cap(64'h8000_0000 + 64'(k * 4), 32'h0000_0013 + 32'(k), 1'b1);
            if (k == 0) chk("latency_tvalid", AXW'(M_AXIS_tvalid), AXW'(1));
        end
        idle(4);
        chk("t1_drained", AXW'(sb.size()), '0);

        // Overflow with stalled sink, then clear and drain
        M_AXIS_tready = 1'b0;
        for (int k = 0; k < 20; k++) cap(64'h4000 + 64'(k), 32'hA000_0000 + 32'(k), k < 16);
        idle(1);
        chk("t2_drop4", AXW'(drop_count), AXW'(4));
        chk("t2_tvalid_held", AXW'(M_AXIS_tvalid), AXW'(1));
        ctrl_write(8'd3, 64'd0);
        chk("t2_drop_clear", AXW'(drop_count), '0);
        M_AXIS_tready = 1'b1;
        idle(20);
        chk("t2_drained", AXW'(sb.size()), '0);

        // PC range filter, inclusive bounds
        tlast_interval = 32'd1;
        ctrl_write(8'd1, 64'h1000);
        ctrl_write(8'd2, 64'h1FFF);
        ctrl_write(8'd0, 64'd3);
        cap(64'h0FFF, 32'h1, 1'b0);
        cap(64'h1000, 32'h2, 1'b1);
        cap(64'h1FFF, 32'h3, 1'b1);
        cap(64'h2000, 32'h4, 1'b0);
        idle(4);
        chk("t3_drained", AXW'(sb.size()), '0);
        ctrl_write(8'd0, 64'd1);

        // Idle timeout terminator
        tlast_interval = 32'd4;
        cap(64'h5000, 32'h11, 1'b1);
        cap(64'h5004, 32'h12, 1'b1);
        sb.push_back('{d: '0, l: 1'b1});
        model_beat = 0;
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (M_AXIS_tvalid && seen == 0) seen = k;
        end
        chk("t4_term_delay", AXW'(seen), AXW'(9));
        chk("t4_drained", AXW'(sb.size()), '0);

        // Reset mid-stream discards queued beats
        M_AXIS_tready = 1'b0;
        tlast_interval = 32'd8;
        for (int k = 0; k < 5; k++) cap(64'h6000 + 64'(k), 32'h20 + 32'(k), 1'b0);
        chk("t5_queued", AXW'(M_AXIS_tvalid), AXW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", AXW'(M_AXIS_tvalid), '0);
        chk("t5_rst_tdata", M_AXIS_tdata, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_beat = 0;
        tlast_interval = 32'd2;
        M_AXIS_tready = 1'b1;
        for (int k = 0; k < 4; k++) cap(64'h7000 + 64'(k), 32'h30 + 32'(k), 1'b1);
        idle(4);
        chk("t5_drained", AXW'(sb.size()), '0);

        // Held write enable performs a single write
        tlast_interval = 32'd1;
        ctrl_addr = 8'd0;
        ctrl_wdata = 64'd0;
        ctrl_write_enable = 1'b1;
        idle(1);
        ctrl_wdata = 64'd1;
        idle(9);
        ctrl_write_enable = 1'b0;
        idle(1);
        cap(64'h9000, 32'h40, 1'b0);
        idle(3);
        chk("t6_trace_off", AXW'(M_AXIS_tvalid), '0);
        ctrl_write(8'd0, 64'd1);
        cap(64'h9004, 32'h41, 1'b1);
        idle(3);
        chk("t6_drained", AXW'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
